// File: rtl/jtcop_sndlatch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtcop_sndlatch_if                                             |
// | Purpose  : Bundle for the main-CPU -> sound-CPU command channel.          |
// |            master : main-CPU write side plus the sound-side latch read    |
// |                     (main_we, main_din, snd_ack driven; status observed)  |
// |            slave  : the command latch itself (jtcop_sndlatch)             |
// | Signals  : main_we  1  write strobe, one clk per byte                     |
// |            main_din 8  command byte                                       |
// |            snd_ack  1  sound CPU latch read (nmi_clr), level              |
// |            latch    8  head byte presented to the sound CPU               |
// |            snreq    1  sound request, rising edge raises the NMI          |
// |            full     1  FIFO full                                          |
// |            empty    1  FIFO empty (in-flight byte counts until popped)    |
// |            ovf      1  sticky overflow                                    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface jtcop_sndlatch_if;
  logic       main_we;
  logic [7:0] main_din;
  logic       snd_ack;
  logic [7:0] latch;
  logic       snreq;
  logic       full;
  logic       empty;
  logic       ovf;

  modport master (
    output main_we, main_din, snd_ack,
    input  latch, snreq, full, empty, ovf
  );

  modport slave (
    input  main_we, main_din, snd_ack,
    output latch, snreq, full, empty, ovf
  );
endinterface
`default_nettype wire

// File: rtl/jtcop_sndlatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtcop_sndlatch                                                |
// | Purpose  : Sound-command channel. Queues main-CPU command writes in a     |
// |            2**AW deep FIFO and hands them to the sound CPU one at a time: |
// |            raise snreq with the byte on latch, wait for the latch read    |
// |            (snd_ack high then low), pop, then keep snreq low for GAP clk. |
// | Ports    : clk, rst (synchronous, active-high)                           |
// |            bus (jtcop_sndlatch_if.slave): main_we, main_din, snd_ack in;  |
// |            latch, snreq, full, empty, ovf out                             |
// | Params   : AW (FIFO address width), GAP (low gap, >= 2),                  |
// |            TIMEOUT (REQ cycles before a re-pulse, retry option only)      |
// | Options  : `define JTCOP_SNDLATCH_RETRY_EN re-pulses snreq (2 clk low)    |
// |            after TIMEOUT clk in REQ without an ack, same byte, no pop.    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module jtcop_sndlatch #(
  parameter int AW      = 3,
  parameter int GAP     = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  jtcop_sndlatch_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int GW    = $clog2(GAP);
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

`ifdef JTCOP_SNDLATCH_RETRY_EN
  localparam int SW = 3;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`else
  localparam int SW = 2;
`endif

  localparam logic [SW-1:0] ST_IDLE = SW'(0);
  localparam logic [SW-1:0] ST_REQ  = SW'(1);
  localparam logic [SW-1:0] ST_ACK  = SW'(2);
  localparam logic [SW-1:0] ST_GAP  = SW'(3);
`ifdef JTCOP_SNDLATCH_RETRY_EN
  localparam logic [SW-1:0] ST_RLOW = SW'(4);
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;

  // Handshake state and outputs
  logic [SW-1:0] state_q, state_d;
  logic [7:0]    latch_q, latch_d;
  logic          snreq_q, snreq_d;
  logic [GW-1:0] gap_q, gap_d;
`ifdef JTCOP_SNDLATCH_RETRY_EN
  logic [TW-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT only has meaning with the retry option; referenced here so the
  // parameter list stays identical in both builds.
  if (TIMEOUT > 0) begin : g_no_retry
  end
`endif

  logic pop;
  logic wr_ok;

  // The byte leaves the FIFO only once the sound CPU has finished its read.
  assign pop   = (state_q == ST_ACK) && !bus.snd_ack;
  // A pop in the same clk frees the slot, so a write to a full FIFO is kept.
  assign wr_ok = bus.main_we && (!full_q || pop);

  // ---------------------------------------------------------------- FIFO --
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
    ovf_d   = ovf_q | (bus.main_we & ~wr_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.main_din;
    end
  end

  // ------------------------------------------------- FSM: state register --
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------- FSM: next state --
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty_q) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.snd_ack) begin
          state_d = ST_ACK;
        end
`ifdef JTCOP_SNDLATCH_RETRY_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ST_RLOW;
        end
`endif
      end
      ST_ACK:  if (!bus.snd_ack) state_d = ST_GAP;
      ST_GAP:  if (gap_q == '0) state_d = ST_IDLE;
`ifdef JTCOP_SNDLATCH_RETRY_EN
      ST_RLOW: if (gap_q == '0) state_d = ST_REQ;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------- FSM: outputs --
  always_comb begin
    latch_d = latch_q;
    gap_d   = gap_q;
    // snreq is a registered copy of "in REQ", so it rises on the same edge
    // that loads the latch and drops on the edge that leaves REQ.
    snreq_d = (state_d == ST_REQ);

    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
      latch_d = mem_q[rd_ptr_q];
    end

    if ((state_q == ST_ACK) && (state_d == ST_GAP)) begin
      gap_d = GW'(GAP - 1);
    end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
      gap_d = gap_q - 1'b1;
    end
`ifdef JTCOP_SNDLATCH_RETRY_EN
    // The gap counter doubles as the 2-clk low timer of a re-pulse.
    else if ((state_q == ST_REQ) && (state_d == ST_RLOW)) begin
      gap_d = GW'(1);
    end else if ((state_q == ST_RLOW) && (gap_q != '0)) begin
      gap_d = gap_q - 1'b1;
    end

    // Held at zero outside REQ, so every entry to REQ starts a fresh count.
    tmo_d = (state_q == ST_REQ) ? tmo_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      latch_q  <= 8'h00;
      snreq_q  <= 1'b0;
      gap_q    <= '0;
`ifdef JTCOP_SNDLATCH_RETRY_EN
      tmo_q    <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      latch_q  <= latch_d;
      snreq_q  <= snreq_d;
      gap_q    <= gap_d;
`ifdef JTCOP_SNDLATCH_RETRY_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.latch = latch_q;
  assign bus.snreq = snreq_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_jtcop_sndlatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtcop_sndlatch                                             |
// | Purpose  : Self-checking bench for jtcop_sndlatch (AW=3, GAP=16,          |
// |            TIMEOUT=64). Plays both the main CPU and the sound CPU.        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_jtcop_sndlatch;

  localparam int GAP_TB   = 16;
  localparam int DEPTH_TB = 8;

  logic clk;
  logic rst;

  jtcop_sndlatch_if bus ();

  jtcop_sndlatch #(
    .AW      (3),
    .GAP     (GAP_TB),
    .TIMEOUT (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // snreq edge tracking, updated on every sample
  int rises     = 0;
  int low_run   = 1000;
  int last_gap  = 1000;
  bit prev_req  = 1'b0;

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic       ack;
    logic       exp_snreq;
    logic [7:0] exp_latch;
    logic       exp_empty;
  } vec_t;

  vec_t vt [9];

  // reference model / responder state for the randomized run
  logic [7:0] mq [$];
  bit         movf;
  bit         ropen;
  int         rdelay;
  int         rhold;
  logic       rack;
  logic       rwe;
  logic [7:0] rdin;
  bit         rpop;
  bit         racc;
  int         r0;
  logic       samp [81];
  int         nhigh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, sample at the falling edge.
  task automatic step(input logic we, input logic [7:0] din, input logic ack);
    bus.main_we  = we;
    bus.main_din = din;
    bus.snd_ack  = ack;
    @(posedge clk);
    @(negedge clk);
    if ((bus.snreq === 1'b1) && !prev_req) begin
      rises++;
      last_gap = low_run;
    end
    low_run  = (bus.snreq === 1'b1) ? 0 : low_run + 1;
    prev_req = (bus.snreq === 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst      = 1'b0;
    prev_req = 1'b0;
    low_run  = 1000;
    last_gap = 1000;
  endtask

  // Sound-CPU side of one transfer: wait for the request, check the byte,
  // hold the read for ack_len clk, release it.
  task automatic deliver(input logic [7:0] exp, input int ack_len, input string tag);
    int n;
    n = 0;
    while ((bus.snreq !== 1'b1) && (n < 300)) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    check({tag, "_req_seen"}, 32'(n < 300), 32'd1);
    check({tag, "_latch"}, 32'(bus.latch), 32'(exp));
    check({tag, "_gap"}, 32'(last_gap >= GAP_TB), 32'd1);
    for (int k = 0; k < ack_len; k++) begin
      step(1'b0, 8'h00, 1'b1);
      check({tag, "_snreq_in_ack"}, 32'(bus.snreq), 32'd0);
      check({tag, "_latch_hold"}, 32'(bus.latch), 32'(exp));
    end
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    vt[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0};
    vt[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1};
    vt[7] = '{1'b1, 8'h6B, 1'b0, 1'b0, 8'h5A, 1'b0};
    vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0};  // read during the gap

    bus.main_we  = 1'b0;
    bus.main_din = 8'h00;
    bus.snd_ack  = 1'b0;
    rst          = 1'b1;

    // ---- reset state
    do_reset();
    step(1'b0, 8'h00, 1'b0);
    check("rst_snreq", 32'(bus.snreq), 32'd0);
    check("rst_latch", 32'(bus.latch), 32'h00);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);

    // ---- single byte, cycle by cycle
    for (int i = 0; i < 9; i++) begin
      step(vt[i].we, vt[i].din, vt[i].ack);
      check($sformatf("t2_snreq_%0d", i), 32'(bus.snreq), 32'(vt[i].exp_snreq));
      check($sformatf("t2_latch_%0d", i), 32'(bus.latch), 32'(vt[i].exp_latch));
      check($sformatf("t2_empty_%0d", i), 32'(bus.empty), 32'(vt[i].exp_empty));
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check($sformatf("t2_gap_low_%0d", i), 32'(bus.snreq), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0);
    check("t2_next_req", 32'(bus.snreq), 32'd1);
    check("t2_next_latch", 32'(bus.latch), 32'h6B);
    deliver(8'h6B, 1, "t2_6b");
    check("t2_empty_end", 32'(bus.empty), 32'd1);

    // ---- burst of three
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    r0 = rises;
    deliver(8'h11, 2, "t3_11");
    deliver(8'h22, 2, "t3_22");
    deliver(8'h33, 2, "t3_33");
    check("t3_rises", 32'(rises - r0), 32'd3);
    check("t3_empty", 32'(bus.empty), 32'd1);

    // ---- overflow: nine writes, no reads
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 7) check("t4_full_at7", 32'(bus.full), 32'd0);
      if (i == 8) begin
        check("t4_full_at8", 32'(bus.full), 32'd1);
        check("t4_ovf_at8",  32'(bus.ovf),  32'd0);
      end
    end
    check("t4_ovf_at9",  32'(bus.ovf),  32'd1);
    check("t4_full_at9", 32'(bus.full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      deliver(8'(i), 1, $sformatf("t4_b%0d", i));
    end
    check("t4_empty", 32'(bus.empty), 32'd1);
    r0 = rises;
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0);
    check("t4_no_9th", 32'(rises - r0), 32'd0);
    check("t4_ovf_sticky", 32'(bus.ovf), 32'd1);

    // ---- write on the pop edge of a full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    check("t5_full", 32'(bus.full), 32'd1);
    check("t5_req", 32'(bus.snreq), 32'd1);
    check("t5_latch", 32'(bus.latch), 32'hA0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hEE, 1'b0);
    check("t5_full_after", 32'(bus.full), 32'd1);
    check("t5_ovf_after",  32'(bus.ovf),  32'd0);
    for (int i = 1; i < 8; i++) deliver(8'hA0 + 8'(i), 1, $sformatf("t5_a%0d", i));
    deliver(8'hEE, 1, "t5_ee");
    check("t5_empty", 32'(bus.empty), 32'd1);
    check("t5_ovf_end", 32'(bus.ovf), 32'd0);

    // ---- reset while a request is pending
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC1 + 8'(i), 1'b0);
    check("t6_req_before", 32'(bus.snreq), 32'd1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("t6_snreq_rst", 32'(bus.snreq), 32'd0);
    check("t6_empty_rst", 32'(bus.empty), 32'd1);
    rst = 1'b0;
    r0  = rises;
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0);
    check("t6_no_req", 32'(rises - r0), 32'd0);
    check("t6_empty_end", 32'(bus.empty), 32'd1);

`ifdef JTCOP_SNDLATCH_RETRY_EN
    // ---- re-pulse after 64 clk without a read
    do_reset();
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    samp[0] = bus.snreq;
    for (int k = 1; k < 81; k++) begin
      step(1'b0, 8'h00, 1'b0);
      samp[k] = bus.snreq;
    end
    nhigh = 0;
    for (int k = 0; k < 64; k++) if (samp[k] === 1'b1) nhigh++;
    check("rt_high_64", 32'(nhigh), 32'd64);
    check("rt_low_a", 32'(samp[64]), 32'd0);
    check("rt_low_b", 32'(samp[65]), 32'd0);
    check("rt_rerise", 32'(samp[66]), 32'd1);
    check("rt_latch", 32'(bus.latch), 32'h77);
    check("rt_no_pop", 32'(bus.empty), 32'd0);
    deliver(8'h77, 1, "rt_77");
`endif

    // ---- randomized traffic against a queue model
    do_reset();
    mq.delete();
    movf   = 1'b0;
    ropen  = 1'b0;
    rdelay = 0;
    rhold  = 0;
    rack   = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (c < 350)      rwe = ($urandom_range(0, 23) == 0);
      else if (c < 700) rwe = ($urandom_range(0, 2) == 0);
      else              rwe = 1'b0;
      rdin = 8'($urandom);

      if (ropen) begin
        if (rhold > 0) begin
          rack = 1'b1;
          rhold--;
        end else begin
          rack = 1'b0;
        end
      end else if (bus.snreq === 1'b1) begin
        if (rdelay == 0) begin
          rack  = 1'b1;
          rhold = $urandom_range(0, 3);
        end else begin
          rack = 1'b0;
          rdelay--;
        end
      end else begin
        rack = ($urandom_range(0, 9) == 0);  // stray read, must be ignored
      end

      rpop = ropen && !rack;
      racc = rwe && ((mq.size() < DEPTH_TB) || rpop);
      if (rwe && !racc) movf = 1'b1;
      if (!ropen && rack && (bus.snreq === 1'b1)) begin
        ropen = 1'b1;
      end else if (rpop) begin
        ropen  = 1'b0;
        rdelay = $urandom_range(0, 5);
      end

      r0 = rises;
      step(rwe, rdin, rack);
      if (rpop) void'(mq.pop_front());
      if (racc) mq.push_back(rdin);

      check("rnd_full",  32'(bus.full),  32'(mq.size() == DEPTH_TB));
      check("rnd_empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("rnd_ovf",   32'(bus.ovf),   32'(movf));
      if (rises != r0) begin
        if (mq.size() == 0) begin
          check("rnd_req_without_data", 32'd0, 32'd1);
        end else begin
          check("rnd_req_latch", 32'(bus.latch), 32'(mq[0]));
          check("rnd_req_gap", 32'(last_gap >= GAP_TB), 32'd1);
        end
      end else if (ropen && (mq.size() != 0)) begin
        check("rnd_latch_hold", 32'(bus.latch), 32'(mq[0]));
      end
    end
    check("rnd_drained", 32'(mq.size()), 32'd0);
    check("rnd_empty_end", 32'(bus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
